// File: rtl/apb_gpio_ext.sv
// APB GPIO block with debounced, synchronised inputs and level/edge pin interrupts.
// Latency: zero-wait APB; pins update 2 edges after a write; IN lags gpio_i by INPUT_STAGES+1 edges.
// Backpressure: none, PREADY is tied high and every access completes in its access phase.
//
// Ports:
//   PCLK, PRESETn               clock, async active-low reset
//   PSEL/PENABLE/PWRITE/PADDR   APB control, 4-bit word address
//   PSTRB/PWDATA/PRDATA         byte strobes, write data, registered read data
//   PREADY/PSLVERR              always ready, error on illegal access
//   irq_o                       registered interrupt request
//   gpio_i/gpio_o/gpio_oe       pin input, pin output value, pin output enable
module apb_gpio_ext #(
  parameter int GPIO_WIDTH   = 32,
  parameter int INPUT_STAGES = 2,
  parameter int DB_CNT_W     = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [3:0]            PADDR,
  input  logic [3:0]            PSTRB,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  irq_o,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe
);

  localparam int W = GPIO_WIDTH;

  localparam logic [3:0] A_MODE    = 4'd0;
  localparam logic [3:0] A_DIR     = 4'd1;
  localparam logic [3:0] A_OUT     = 4'd2;
  localparam logic [3:0] A_IN      = 4'd3;
  localparam logic [3:0] A_TR_TYPE = 4'd4;
  localparam logic [3:0] A_TR_LVL0 = 4'd5;
  localparam logic [3:0] A_TR_LVL1 = 4'd6;
  localparam logic [3:0] A_TR_STAT = 4'd7;
  localparam logic [3:0] A_IRQ_ENA = 4'd8;
  localparam logic [3:0] A_OUT_SET = 4'd9;
  localparam logic [3:0] A_OUT_CLR = 4'd10;
  localparam logic [3:0] A_OUT_TGL = 4'd11;
  localparam logic [3:0] A_DB_ENA  = 4'd12;
  localparam logic [3:0] A_DB_PER  = 4'd13;
  localparam logic [3:0] A_TR_BOTH = 4'd14;
  localparam logic [3:0] A_UNMAP   = 4'd15;

  // Control registers
  logic [W-1:0]        mode_q, dir_q, out_q, tr_type_q, tr_lvl0_q, tr_lvl1_q;
  logic [W-1:0]        tr_stat_q, irq_ena_q, db_ena_q, tr_both_q;
  logic [DB_CNT_W-1:0] db_period_q;

  // Input path state
  logic [W-1:0]        sync_q [INPUT_STAGES];
  logic [W-1:0]        sync;
  logic [W-1:0]        filt_q;
  logic [1:0]          db_pin_cnt_q [W];
  logic [DB_CNT_W-1:0] db_cnt_q;
  logic                db_tick;
  logic [W-1:0]        in_q, in_d_q, rise_q, fall_q;
  logic [W-1:0]        tr_evt, stat_clr;

  // APB decode
  logic        access, setup_rd, bad_acc, wr_en;
  logic [31:0] bmask;
  logic [W-1:0] bm_w, wd_w;
  logic [DB_CNT_W-1:0] bm_db, wd_db;
  logic [31:0] rd_data;

  assign access   = PSEL & PENABLE;
  assign setup_rd = PSEL & ~PENABLE & ~PWRITE;
  assign bad_acc  = (PADDR == A_UNMAP)
                  | (PWRITE & (PADDR == A_IN))
                  | (~PWRITE & ((PADDR == A_OUT_SET) | (PADDR == A_OUT_CLR) | (PADDR == A_OUT_TGL)));
  assign PSLVERR  = access & bad_acc;
  assign PREADY   = 1'b1;
  // Erroring writes are dropped here, so no register below sees them
  assign wr_en    = access & PWRITE & ~bad_acc;

  assign bmask = {{8{PSTRB[3]}}, {8{PSTRB[2]}}, {8{PSTRB[1]}}, {8{PSTRB[0]}}};
  assign bm_w  = bmask[W-1:0];
  assign wd_w  = PWDATA[W-1:0] & bm_w;
  assign bm_db = bmask[DB_CNT_W-1:0];
  assign wd_db = PWDATA[DB_CNT_W-1:0] & bm_db;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      mode_q      <= '0;
      dir_q       <= '0;
      out_q       <= '0;
      tr_type_q   <= '0;
      tr_lvl0_q   <= '0;
      tr_lvl1_q   <= '0;
      irq_ena_q   <= '0;
      db_ena_q    <= '0;
      tr_both_q   <= '0;
      db_period_q <= '0;
    end else if (wr_en) begin
      case (PADDR)
        A_MODE:    mode_q      <= (mode_q    & ~bm_w) | wd_w;
        A_DIR:     dir_q       <= (dir_q     & ~bm_w) | wd_w;
        A_OUT:     out_q       <= (out_q     & ~bm_w) | wd_w;
        A_TR_TYPE: tr_type_q   <= (tr_type_q & ~bm_w) | wd_w;
        A_TR_LVL0: tr_lvl0_q   <= (tr_lvl0_q & ~bm_w) | wd_w;
        A_TR_LVL1: tr_lvl1_q   <= (tr_lvl1_q & ~bm_w) | wd_w;
        A_IRQ_ENA: irq_ena_q   <= (irq_ena_q & ~bm_w) | wd_w;
        A_OUT_SET: out_q       <= out_q | wd_w;
        A_OUT_CLR: out_q       <= out_q & ~wd_w;
        A_OUT_TGL: out_q       <= out_q ^ wd_w;
        A_DB_ENA:  db_ena_q    <= (db_ena_q  & ~bm_w) | wd_w;
        A_DB_PER:  db_period_q <= (db_period_q & ~bm_db) | wd_db;
        A_TR_BOTH: tr_both_q   <= (tr_both_q & ~bm_w) | wd_w;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (PADDR)
      A_MODE:    rd_data[W-1:0]        = mode_q;
      A_DIR:     rd_data[W-1:0]        = dir_q;
      A_OUT:     rd_data[W-1:0]        = out_q;
      A_IN:      rd_data[W-1:0]        = in_q;
      A_TR_TYPE: rd_data[W-1:0]        = tr_type_q;
      A_TR_LVL0: rd_data[W-1:0]        = tr_lvl0_q;
      A_TR_LVL1: rd_data[W-1:0]        = tr_lvl1_q;
      A_TR_STAT: rd_data[W-1:0]        = tr_stat_q;
      A_IRQ_ENA: rd_data[W-1:0]        = irq_ena_q;
      A_DB_ENA:  rd_data[W-1:0]        = db_ena_q;
      A_DB_PER:  rd_data[DB_CNT_W-1:0] = db_period_q;
      A_TR_BOTH: rd_data[W-1:0]        = tr_both_q;
      default:   rd_data               = '0;
    endcase
  end

  // Read data is captured in the setup phase and held through the access phase
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)      PRDATA <= '0;
    else if (setup_rd) PRDATA <= rd_data;
  end

  // Open-drain style: MODE pins only ever drive low by releasing OE when OUT=1
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      gpio_o  <= '0;
      gpio_oe <= '0;
    end else begin
      gpio_o  <= ~mode_q & out_q;
      gpio_oe <= dir_q & ~(mode_q & out_q);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < INPUT_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < INPUT_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign sync = sync_q[INPUT_STAGES-1];

  // Shared debounce prescaler; a period write restarts the phase
  assign db_tick = (db_cnt_q == db_period_q);
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                         db_cnt_q <= '0;
    else if (wr_en && PADDR == A_DB_PER)  db_cnt_q <= '0;
    else if (db_tick)                     db_cnt_q <= '0;
    else                                  db_cnt_q <= db_cnt_q + {{(DB_CNT_W-1){1'b0}}, 1'b1};
  end

  // Disabled pins keep filt tracking sync with a cleared counter, so that
  // re-enabling the filter starts from the current pin level.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      filt_q <= '0;
      for (int n = 0; n < W; n++) db_pin_cnt_q[n] <= 2'd0;
    end else begin
      for (int n = 0; n < W; n++) begin
        if (!db_ena_q[n]) begin
          filt_q[n]       <= sync[n];
          db_pin_cnt_q[n] <= 2'd0;
        end else if (db_tick) begin
          if (sync[n] != filt_q[n]) begin
            // Third consecutive mismatching tick accepts the new level
            if (db_pin_cnt_q[n] == 2'd2) begin
              filt_q[n]       <= sync[n];
              db_pin_cnt_q[n] <= 2'd0;
            end else begin
              db_pin_cnt_q[n] <= db_pin_cnt_q[n] + 2'd1;
            end
          end else begin
            db_pin_cnt_q[n] <= 2'd0;
          end
        end
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      in_q   <= '0;
      in_d_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      in_q   <= (db_ena_q & filt_q) | (~db_ena_q & sync);
      in_d_q <= in_q;
      rise_q <= in_q & ~in_d_q;
      fall_q <= ~in_q & in_d_q;
    end
  end

  assign tr_evt = (~tr_type_q & ((tr_lvl0_q & ~in_q) | (tr_lvl1_q & in_q)))
                | ( tr_type_q & ((tr_both_q & (rise_q | fall_q))
                               | (~tr_both_q & ((tr_lvl0_q & fall_q) | (tr_lvl1_q & rise_q)))));

  assign stat_clr = (wr_en && PADDR == A_TR_STAT) ? wd_w : '0;

  // Set is applied after clear so a coincident event wins
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tr_stat_q <= '0;
      irq_o     <= 1'b0;
    end else begin
      tr_stat_q <= (tr_stat_q & ~stat_clr) | tr_evt;
      irq_o     <= |(irq_ena_q & tr_stat_q);
    end
  end

endmodule

// File: tb/tb_apb_gpio_ext.sv
// Self-checking bench for apb_gpio_ext: randomized register traffic against a
// register-file model, plus pin, debounce, trigger and reset scenarios.
module tb_apb_gpio_ext;

  localparam int W   = 8;
  localparam int STG = 2;
  localparam int DBW = 16;
  localparam logic [31:0] WM  = 32'h0000_00FF;
  localparam logic [31:0] DBM = 32'h0000_FFFF;

  logic          PCLK, PRESETn, PSEL, PENABLE, PWRITE;
  logic [3:0]    PADDR, PSTRB;
  logic [31:0]   PWDATA, PRDATA;
  logic          PREADY, PSLVERR, irq_o;
  logic [W-1:0]  gpio_i, gpio_o, gpio_oe;

  apb_gpio_ext #(.GPIO_WIDTH(W), .INPUT_STAGES(STG), .DB_CNT_W(DBW)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PSTRB(PSTRB), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .irq_o(irq_o), .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference register file, indexed by word address
  logic [31:0] m [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  function automatic logic exp_err(input logic wr, input logic [3:0] a);
    return (a == 4'd15) || (wr && a == 4'd3) || (!wr && a >= 4'd9 && a <= 4'd11);
  endfunction

  function automatic logic [31:0] exp_read(input logic [3:0] a);
    if (a == 4'd3 || a == 4'd7 || (a >= 4'd9 && a <= 4'd11) || a == 4'd15) return 32'h0;
    return m[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i] = 32'h0;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] bm, dm;
    bm = 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) bm = bm | (32'hFF << (8 * b));
    dm = d & bm;
    case (a)
      4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd12, 4'd14: m[a] = ((m[a] & ~bm) | dm) & WM;
      4'd13: m[a] = ((m[a] & ~bm) | dm) & DBM;
      4'd9:  m[2] = (m[2] | dm) & WM;
      4'd10: m[2] = m[2] & ~dm;
      4'd11: m[2] = (m[2] ^ dm) & WM;
      default: ;
    endcase
  endtask

  // Starts and ends #1 after a rising edge
  task automatic apb_xfer(input logic wr, input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = s;
    @(posedge PCLK); #1;
    chk("setup_slverr", {31'b0, PSLVERR}, 32'h0);
    PENABLE = 1'b1;
    #1;
    rd  = PRDATA;
    err = PSLVERR;
    chk("pready", {31'b0, PREADY}, 32'h1);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic do_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    logic err;
    apb_xfer(1'b1, a, d, s, rd, err);
    chk($sformatf("wr_err_a%0d", a), {31'b0, err}, {31'b0, exp_err(1'b1, a)});
    model_write(a, d, s);
  endtask

  task automatic do_rd(input logic [3:0] a, output logic [31:0] v);
    logic err;
    apb_xfer(1'b0, a, 32'h0, 4'h0, v, err);
    chk($sformatf("rd_err_a%0d", a), {31'b0, err}, {31'b0, exp_err(1'b0, a)});
  endtask

  task automatic cfg_clean();
    logic [3:0] ctl [10] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd12, 4'd13, 4'd14};
    for (int i = 0; i < 10; i++) do_wr(ctl[i], 32'h0, 4'hF);
    do_wr(4'd7, 32'hFFFF_FFFF, 4'hF);
  endtask

  initial begin
    logic [31:0] v, g, old_g, lv0, lv1, ena, both, rise, fall, e;
    logic [3:0]  a;
    int          cyc;
    logic        found;

    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PSTRB = '0; PWDATA = '0; gpio_i = '0;
    model_reset();
    tick(3);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_gpio_o", {24'b0, gpio_o}, 32'h0);
    chk("rst_gpio_oe", {24'b0, gpio_oe}, 32'h0);
    chk("rst_irq", {31'b0, irq_o}, 32'h0);
    PRESETn = 1'b1;
    tick(1);
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      do_rd(a, v);
      chk($sformatf("rst_rd_a%0d", i), v, 32'h0);
    end

    // Randomized register traffic (inputs held low, so IN reads 0)
    for (int i = 0; i < 120; i++) begin
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1 && a != 4'd7) begin
        do_wr(a, $urandom, 4'($urandom_range(0, 15)));
      end else begin
        do_rd(a, v);
        if (a != 4'd7) chk($sformatf("rand_rd_a%0d", a), v, exp_read(a));
      end
    end
    tick(2);
    chk("rand_gpio_o", {24'b0, gpio_o}, ~m[0] & m[2] & WM);
    chk("rand_gpio_oe", {24'b0, gpio_oe}, m[1] & ~(m[0] & m[2]) & WM);

    // Set/clear/toggle sequence
    cfg_clean();
    do_wr(4'd1, 32'hFF, 4'hF);
    do_wr(4'd2, 32'hF0, 4'hF);
    do_wr(4'd9, 32'h0F, 4'hF);
    do_wr(4'd10, 32'h30, 4'hF);
    do_wr(4'd11, 32'h101, 4'hF);
    do_rd(4'd2, v);
    chk("out_ops", v, 32'h1CE & WM);
    tick(1);
    chk("out_ops_gpio_o", {24'b0, gpio_o}, 32'hCE);
    chk("out_ops_gpio_oe", {24'b0, gpio_oe}, 32'hFF);

    // Open-drain mode on pin 0
    do_wr(4'd0, 32'h1, 4'hF);
    do_wr(4'd9, 32'h1, 4'hF);
    tick(1);
    chk("od_hi_gpio_o", {24'b0, gpio_o}, 32'hCE);
    chk("od_hi_gpio_oe", {24'b0, gpio_oe}, 32'hFE);
    do_wr(4'd10, 32'h1, 4'hF);
    tick(1);
    chk("od_lo_gpio_o", {24'b0, gpio_o}, 32'hCE);
    chk("od_lo_gpio_oe", {24'b0, gpio_oe}, 32'hFF);

    // Undebounced input path
    cfg_clean();
    for (int i = 0; i < 6; i++) begin
      g = $urandom & WM;
      gpio_i = g[W-1:0];
      tick(5);
      do_rd(4'd3, v);
      chk("in_sync", v, g);
    end

    // Level triggers and interrupt
    for (int i = 0; i < 5; i++) begin
      lv0 = $urandom & WM; lv1 = $urandom & WM; ena = $urandom & WM;
      do_wr(4'd4, 32'h0, 4'hF);
      do_wr(4'd5, lv0, 4'hF);
      do_wr(4'd6, lv1, 4'hF);
      do_wr(4'd8, ena, 4'hF);
      g = $urandom & WM;
      gpio_i = g[W-1:0];
      tick(6);
      do_wr(4'd7, 32'hFF, 4'hF);
      tick(3);
      e = (lv0 & ~g) | (lv1 & g);
      do_rd(4'd7, v);
      chk("lvl_stat", v, e & WM);
      tick(2);
      chk("lvl_irq", {31'b0, irq_o}, {31'b0, |(ena & e)});
    end

    // Edge triggers
    for (int i = 0; i < 8; i++) begin
      lv0 = $urandom & WM; lv1 = $urandom & WM; both = $urandom & WM;
      do_wr(4'd4, 32'hFF, 4'hF);
      do_wr(4'd5, lv0, 4'hF);
      do_wr(4'd6, lv1, 4'hF);
      do_wr(4'd14, both, 4'hF);
      tick(6);
      do_wr(4'd7, 32'hFF, 4'hF);
      old_g = {24'b0, gpio_i};
      g = $urandom & WM;
      gpio_i = g[W-1:0];
      tick(8);
      rise = g & ~old_g;
      fall = old_g & ~g;
      e = (both & (rise | fall)) | (~both & ((lv0 & fall) | (lv1 & rise)));
      do_rd(4'd7, v);
      chk("edge_stat", v, e & WM);
    end

    // Both-edge interrupt on pin 5 and set-beats-clear collision
    gpio_i = '0;
    tick(6);
    cfg_clean();
    do_wr(4'd4, 32'h20, 4'hF);
    do_wr(4'd14, 32'h20, 4'hF);
    do_wr(4'd8, 32'h20, 4'hF);
    gpio_i[5] = 1'b1;
    tick(8);
    do_rd(4'd7, v);
    chk("both_rise_stat", v, 32'h20);
    chk("both_rise_irq", {31'b0, irq_o}, 32'h1);
    gpio_i[5] = 1'b0;
    tick(3);
    do_wr(4'd7, 32'h20, 4'hF);
    tick(2);
    do_rd(4'd7, v);
    chk("set_wins_stat", v, 32'h20);
    do_wr(4'd7, 32'h20, 4'hF);
    tick(2);
    do_rd(4'd7, v);
    chk("w1c_stat", v, 32'h0);
    tick(1);
    chk("w1c_irq", {31'b0, irq_o}, 32'h0);

    // Debounce on pin 2: a 10-cycle glitch is rejected, a held level is accepted
    cfg_clean();
    do_wr(4'd12, 32'h04, 4'hF);
    do_wr(4'd13, 32'h4, 4'hF);
    gpio_i[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_rd(4'd3, v);
      chk("db_glitch_hi", {31'b0, v[2]}, 32'h0);
    end
    gpio_i[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_rd(4'd3, v);
      chk("db_glitch_lo", {31'b0, v[2]}, 32'h0);
    end
    gpio_i[2] = 1'b1;
    cyc = 0;
    found = 1'b0;
    while (!found && cyc < 15 + STG + 2 + 3) begin
      do_rd(4'd3, v);
      cyc += 2;
      if (v[2]) found = 1'b1;
    end
    chk("db_settle", {31'b0, found}, 32'h1);
    gpio_i[2] = 1'b0;
    do_wr(4'd12, 32'h0, 4'hF);
    tick(4);
    do_rd(4'd3, v);
    chk("db_disable_in", {31'b0, v[2]}, 32'h0);

    // Error accesses change nothing
    do_wr(4'd1, 32'h5A, 4'hF);
    do_rd(4'd15, v);
    chk("unmapped_rd", v, 32'h0);
    do_rd(4'd10, v);
    chk("wo_rd", v, 32'h0);
    do_wr(4'd3, 32'hFFFF_FFFF, 4'hF);
    do_wr(4'd15, 32'hFFFF_FFFF, 4'hF);
    for (int i = 0; i < 15; i++) begin
      a = 4'(i);
      if (a != 4'd3 && a != 4'd7) begin
        do_rd(a, v);
        chk($sformatf("err_nochg_a%0d", i), v, exp_read(a));
      end
    end

    // Narrow width masking, then reset mid-write
    do_wr(4'd1, 32'hFFFF_FFFF, 4'hF);
    do_rd(4'd1, v);
    chk("dir_width", v, 32'hFF);
    do_wr(4'd0, 32'h0, 4'hF);
    do_wr(4'd2, 32'hAA, 4'hF);
    do_wr(4'd4, 32'h0, 4'hF);
    do_wr(4'd6, 32'h20, 4'hF);
    do_wr(4'd8, 32'h20, 4'hF);
    gpio_i[5] = 1'b1;
    tick(6);
    do_rd(4'd2, v);
    chk("pre_rst_out", v, 32'hAA);
    chk("pre_rst_irq", {31'b0, irq_o}, 32'h1);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'd2; PWDATA = 32'h55; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2;
    PRESETn = 1'b0;
    #1;
    chk("arst_prdata", PRDATA, 32'h0);
    chk("arst_gpio_o", {24'b0, gpio_o}, 32'h0);
    chk("arst_gpio_oe", {24'b0, gpio_oe}, 32'h0);
    chk("arst_irq", {31'b0, irq_o}, 32'h0);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PRESETn = 1'b1;
    model_reset();
    tick(1);
    do_rd(4'd2, v);
    chk("post_rst_out", v, 32'h0);
    do_rd(4'd1, v);
    chk("post_rst_dir", v, 32'h0);
    do_rd(4'd7, v);
    chk("post_rst_stat", v, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_gpio_ext.md
APB_GPIO_EXT -- requirements
Module: apb_gpio_ext

Interface
REQ-001 SHALL have parameter GPIO_WIDTH, default 32, number of pins (legal 1..32).
REQ-002 SHALL have parameter INPUT_STAGES, default 2, number of input synchroniser flops (legal >= 2).
REQ-003 SHALL have parameter DB_CNT_W, default 16, width of the debounce prescaler.
REQ-004 SHALL have port PCLK  in  1  the single clock for all logic.
REQ-005 SHALL have port PRESETn  in  1  reset; asynchronous assert, active-low.
REQ-006 SHALL have ports PSEL, PENABLE, PWRITE  in  1 each  standard APB control signals.
REQ-007 SHALL have ports PADDR  in  4, PSTRB  in  4 and PWDATA  in  32  word address, byte strobes and write data.
REQ-008 SHALL have ports PRDATA  out  32, PREADY  out  1 and PSLVERR  out  1.
REQ-009 SHALL have port irq_o  out  1  registered interrupt request.
REQ-010 SHALL have ports gpio_i  in  GPIO_WIDTH, and gpio_o, gpio_oe  out  GPIO_WIDTH.

Function
REQ-011 SHALL use this address map: 0 MODE, 1 DIR, 2 OUT, 3 IN (RO), 4 TR_TYPE, 5 TR_LVL0, 6 TR_LVL1, 7 TR_STAT (W1C), 8 IRQ_ENA, 9 OUT_SET (WO), 10 OUT_CLR (WO), 11 OUT_TGL (WO), 12 DB_ENA, 13 DB_PERIOD, 14 TR_BOTH; address 15 is unmapped.
REQ-012 SHALL drive PREADY=1 permanently; all accesses complete with zero wait states.
REQ-013 SHALL assert PSLVERR only in the access phase (PSEL&PENABLE) of: any access to address 15, a write to IN, or a read of OUT_SET, OUT_CLR or OUT_TGL; an erroring write SHALL change no state.
REQ-014 SHALL register PRDATA on the setup-phase edge (PSEL&~PENABLE&~PWRITE); PRDATA is valid during the access phase; write-only and unmapped addresses SHALL read 0.
REQ-015 SHALL write only bytes with PSTRB[n]=1; register bits at and above GPIO_WIDTH SHALL read 0 and ignore writes; DB_PERIOD SHALL hold DB_CNT_W bits.
REQ-016 OUT_SET / OUT_CLR / OUT_TGL SHALL apply OUT|=D, OUT&=~D and OUT^=D respectively, masked by PSTRB, in a single cycle.
REQ-017 SHALL register gpio_o[n] = MODE[n] ? 0 : OUT[n].
REQ-018 SHALL register gpio_oe[n] = DIR[n] & ~(MODE[n] & OUT[n]); a write at edge k SHALL be visible on the pins after edge k+1.
REQ-019 SHALL pass gpio_i through INPUT_STAGES synchroniser flops to produce sync[n].
REQ-020 Debounce prescaler: SHALL count 0..DB_PERIOD and emit a one-cycle tick when count==DB_PERIOD, then wrap to 0; DB_PERIOD=0 SHALL give a tick every cycle; any write to DB_PERIOD SHALL reset the count to 0.
REQ-021 Per-pin debounce, on each tick: sync!=filt increments a 2-bit counter; on reaching 3 the block SHALL set filt<=sync and clear the counter; sync==filt SHALL clear the counter.
REQ-022 SHALL register IN[n] = DB_ENA[n] ? filt[n] : sync[n]; clearing DB_ENA[n] SHALL load filt[n]<=sync[n] and clear the pin's counter.
REQ-023 Edge detection SHALL compare IN with its one-cycle-delayed copy and register rise/fall pulses.
REQ-024 Trigger event per pin: TR_TYPE=0 (level): LVL0&~IN | LVL1&IN; TR_TYPE=1 (edge): TR_BOTH ? (rise|fall) : (LVL0&fall | LVL1&rise).
REQ-025 TR_STAT SHALL be sticky and set by trigger events; writing 1 SHALL clear a bit; if an event and a clear hit the same bit in the same cycle, set SHALL win.
REQ-026 SHALL register irq_o = |(IRQ_ENA & TR_STAT), one cycle after TR_STAT updates.

Reset
REQ-027 On PRESETn=0, all control registers, TR_STAT, prescaler, debounce counters, filt, edge pulses, PRDATA, gpio_o, gpio_oe and irq_o SHALL go to 0 immediately, without waiting for a clock edge.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer with no register update; synchroniser flops SHALL also reset to 0.

Verification
REQ-029 Write OUT=0x0000_00F0, then OUT_SET 0x0F, OUT_CLR 0x30, OUT_TGL 0x101, with DIR=0xFF and MODE=0 -> OUT reads 0x0000_01CE, gpio_o=0xCE, gpio_oe=0xFF.
REQ-030 Set MODE[0]=1, DIR[0]=1: OUT[0]=1 -> gpio_o[0]=0, gpio_oe[0]=0; OUT[0]=0 -> gpio_oe[0]=1.
REQ-031 Set DB_ENA[2]=1, DB_PERIOD=4; pulse gpio_i[2] high for 10 cycles -> IN[2] stays 0; hold it high -> IN[2]=1 within 15+INPUT_STAGES+2 cycles.
REQ-032 Set TR_TYPE[5]=1, TR_BOTH[5]=1, IRQ_ENA[5]=1; toggle gpio_i[5] 0->1 -> TR_STAT[5]=1 and irq_o=1; write TR_STAT 0x20 with a falling edge in the same cycle -> bit stays 1.
REQ-033 Read address 15 and write address 3 -> PSLVERR=1 during the access phase, PRDATA=0, no state changed.
REQ-034 With GPIO_WIDTH=8, write 0xFFFF_FFFF to DIR -> DIR reads 0x0000_00FF; assert PRESETn low mid-write -> all outputs 0 asynchronously.
